// File: rtl/cond_status_unit.sv
// ARM condition-evaluation unit owning the NZCV status register.
// Tracks in-flight flag setters and stalls lanes whose condition depends on flags.
module cond_status_unit #(
   parameter int NUM_CH   = 1,
   parameter int MAX_PEND = 3,
   parameter int FWD_EN   = 1,
   parameter int NV_MODE  = 0,
   parameter int CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pend_inc,
   output logic                  pend_full,
   input  logic                  sr_we,
   input  logic [3:0]            sr_in,
   input  logic [3:0]            sr_mask,
   input  logic [NUM_CH-1:0]     q_valid,
   input  logic [4*NUM_CH-1:0]   q_cond,
   output logic [NUM_CH-1:0]     q_ready,
   output logic [NUM_CH-1:0]     q_pass,
   output logic [3:0]            status_o,
   input  logic                  stat_clr,
   output logic [CNT_W-1:0]      pass_cnt,
   output logic [CNT_W-1:0]      fail_cnt,
   output logic                  err_o
);

   localparam int PW = $clog2(MAX_PEND + 1);
   localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic [3:0]       r_status;
   logic [PW-1:0]    r_pend;
   logic [CNT_W-1:0] r_pass;
   logic [CNT_W-1:0] r_fail;
   logic             r_err;

   logic [3:0]       w_merged;
   logic [3:0]       w_flags;
   logic             w_retire;
   logic             w_fwd;
   logic             w_hazard;
   logic [PW-1:0]    w_pendNext;
   logic [CNT_W:0]   w_passInc;
   logic [CNT_W:0]   w_failInc;
   logic [CNT_W:0]   w_passSum;
   logic [CNT_W:0]   w_failSum;

   // Odd codes are the complement of the even code below them; only 4'hF breaks the pattern.
   function automatic logic condTrue(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c & !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z & (n == v);
         default: base = 1'b1;
      endcase
      if (cond == 4'hF)
         return (NV_MODE != 0);
      return base ^ cond[0];
   endfunction

   assign w_merged  = (r_status & ~sr_mask) | (sr_in & sr_mask);
   assign w_retire  = sr_we && (r_pend != '0);
   assign w_fwd     = (FWD_EN != 0) && sr_we && (r_pend == PW'(1)) && !pend_inc;
   assign w_flags   = w_fwd ? w_merged : r_status;
   assign w_hazard  = (r_pend != '0) && !w_fwd;
   assign pend_full = (r_pend == PMAX);

   always_comb begin
      w_pendNext = r_pend;
      if (pend_inc && !w_retire && !pend_full)
         w_pendNext = r_pend + PW'(1);
      else if (!pend_inc && w_retire)
         w_pendNext = r_pend - PW'(1);
   end

   // Codes E and F are flag-independent, so they never stall.
   always_comb begin
      q_ready   = '0;
      q_pass    = '0;
      w_passInc = '0;
      w_failInc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         q_ready[i] = !(w_hazard && (q_cond[4*i+1 +: 3] != 3'b111));
         q_pass[i]  = condTrue(q_cond[4*i +: 4], w_flags);
         w_passInc  = w_passInc + (CNT_W+1)'(q_valid[i] & q_ready[i] & q_pass[i]);
         w_failInc  = w_failInc + (CNT_W+1)'(q_valid[i] & q_ready[i] & !q_pass[i]);
      end
   end

   assign w_passSum = {1'b0, r_pass} + w_passInc;
   assign w_failSum = {1'b0, r_fail} + w_failInc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_status <= '0;
         r_pend   <= '0;
         r_pass   <= '0;
         r_fail   <= '0;
         r_err    <= 1'b0;
      end else begin
         if (sr_we)
            r_status <= w_merged;
         r_pend <= w_pendNext;
         if (pend_inc && pend_full)
            r_err <= 1'b1;
         if (stat_clr) begin
            r_pass <= '0;
            r_fail <= '0;
         end else begin
            r_pass <= w_passSum[CNT_W] ? CMAX : w_passSum[CNT_W-1:0];
            r_fail <= w_failSum[CNT_W] ? CMAX : w_failSum[CNT_W-1:0];
         end
      end
   end

   assign status_o = r_status;
   assign pass_cnt = r_pass;
   assign fail_cnt = r_fail;
   assign err_o    = r_err;

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed bench: dutA (2 lanes, 2-bit counters, forwarding, NV never) and
// dutB (1 lane, forwarding off, NV always) share stimulus; dutB lane 0 mirrors dutA lane 0.
module tb_cond_status_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pendInc = 1'b0;
   logic        srWe = 1'b0;
   logic [3:0]  srIn = '0;
   logic [3:0]  srMask = '0;
   logic        statClr = 1'b0;
   logic [1:0]  qValidA = '0;
   logic [7:0]  qCondA = '0;

   logic        aFull, bFull, aErr, bErr;
   logic [1:0]  aReady, aPass;
   logic [0:0]  bReady, bPass;
   logic [3:0]  aStatus, bStatus;
   logic [1:0]  aPassCnt, aFailCnt;
   logic [15:0] bPassCnt, bFailCnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cond_status_unit #(.NUM_CH(2), .MAX_PEND(3), .FWD_EN(1), .NV_MODE(0), .CNT_W(2)) dutA (
      .clk(clk), .rst(rst), .pend_inc(pendInc), .pend_full(aFull),
      .sr_we(srWe), .sr_in(srIn), .sr_mask(srMask),
      .q_valid(qValidA), .q_cond(qCondA), .q_ready(aReady), .q_pass(aPass),
      .status_o(aStatus), .stat_clr(statClr), .pass_cnt(aPassCnt), .fail_cnt(aFailCnt),
      .err_o(aErr));

   cond_status_unit #(.NUM_CH(1), .MAX_PEND(3), .FWD_EN(0), .NV_MODE(1), .CNT_W(16)) dutB (
      .clk(clk), .rst(rst), .pend_inc(pendInc), .pend_full(bFull),
      .sr_we(srWe), .sr_in(srIn), .sr_mask(srMask),
      .q_valid(qValidA[0:0]), .q_cond(qCondA[3:0]), .q_ready(bReady), .q_pass(bPass),
      .status_o(bStatus), .stat_clr(statClr), .pass_cnt(bPassCnt), .fail_cnt(bFailCnt),
      .err_o(bErr));

   // Reference decode written directly from the condition table.
   function automatic logic refCond(input logic [3:0] cond, input logic [3:0] f, input int nv);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return nv != 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeFlags(input logic [3:0] val);
      srWe = 1'b1; srIn = val; srMask = 4'hF;
      tick();
      srWe = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++;
      if (aStatus !== 4'h0 || bStatus !== 4'h0) begin
         errors++; $display("[TB] FAIL reset_status got %h/%h want 0", aStatus, bStatus);
      end
      checks++;
      if (aReady !== 2'b11 || bReady !== 1'b1 || aFull !== 1'b0 || aErr !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_ctrl ready %b/%b full %b err %b", aReady, bReady, aFull, aErr);
      end
      checks++;
      if (aPassCnt !== 2'd0 || aFailCnt !== 2'd0 || bPassCnt !== 16'd0 || bFailCnt !== 16'd0) begin
         errors++; $display("[TB] FAIL reset_cnt got %0d %0d %0d %0d want 0", aPassCnt, aFailCnt, bPassCnt, bFailCnt);
      end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      writeFlags(4'b0100);
      checks++;
      if (aStatus !== 4'b0100 || bStatus !== 4'b0100) begin
         errors++; $display("[TB] FAIL basic_status got %b/%b want 0100", aStatus, bStatus);
      end
      qCondA = 8'h00; #1;
      checks++;
      if (aPass[0] !== 1'b1 || bPass !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_eq got %b/%b want 1", aPass[0], bPass);
      end
      qCondA = 8'h01; #1;
      checks++;
      if (aPass[0] !== 1'b0 || bPass !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_ne got %b/%b want 0", aPass[0], bPass);
      end
      qCondA = 8'h09; #1;
      checks++;
      if (aPass[0] !== 1'b1 || bPass !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_ls got %b/%b want 1", aPass[0], bPass);
      end
   endtask

   task automatic test_sweep();
      logic [3:0] fl, cd;
      for (int f = 0; f < 16; f++) begin
         fl = 4'(f);
         writeFlags(fl);
         for (int c = 0; c < 16; c++) begin
            cd = 4'(c);
            qCondA = {~cd, cd};
            #1;
            checks++;
            if (aPass[0] !== refCond(cd, fl, 0) || aPass[1] !== refCond(~cd, fl, 0)) begin
               errors++; $display("[TB] FAIL sweep_nv0 flags %b cond %h got %b", fl, cd, aPass);
            end
            checks++;
            if (bPass !== refCond(cd, fl, 1)) begin
               errors++; $display("[TB] FAIL sweep_nv1 flags %b cond %h got %b want %b", fl, cd, bPass, refCond(cd, fl, 1));
            end
         end
      end
   endtask

   task automatic test_mask();
      writeFlags(4'b1111);
      srWe = 1'b1; srIn = 4'b0000; srMask = 4'b1100;
      tick();
      srWe = 1'b0;
      checks++;
      if (aStatus !== 4'b0011 || bStatus !== 4'b0011) begin
         errors++; $display("[TB] FAIL mask_partial got %b/%b want 0011", aStatus, bStatus);
      end
      srMask = 4'b0000; srWe = 1'b1; srIn = 4'b1100;
      tick();
      srWe = 1'b0;
      checks++;
      if (aStatus !== 4'b0011) begin
         errors++; $display("[TB] FAIL mask_zero got %b want 0011", aStatus);
      end
   endtask

   task automatic test_hazard();
      writeFlags(4'b0000);
      pendInc = 1'b1;
      tick();
      pendInc = 1'b0;
      qCondA = {4'hE, 4'h0}; qValidA = 2'b11;
      #1;
      checks++;
      if (aReady !== 2'b10 || bReady !== 1'b0) begin
         errors++; $display("[TB] FAIL hazard_stall got %b/%b want 10/0", aReady, bReady);
      end
      tick();
      srWe = 1'b1; srIn = 4'b0100; srMask = 4'hF;
      #1;
      checks++;
      if (aReady !== 2'b11 || aPass[0] !== 1'b1) begin
         errors++; $display("[TB] FAIL hazard_fwd ready %b pass %b want 11/1", aReady, aPass[0]);
      end
      checks++;
      if (bReady !== 1'b0) begin
         errors++; $display("[TB] FAIL hazard_nofwd got %b want 0", bReady);
      end
      tick();
      srWe = 1'b0;
      #1;
      checks++;
      if (bReady !== 1'b1 || bPass !== 1'b1) begin
         errors++; $display("[TB] FAIL hazard_after ready %b pass %b want 1/1", bReady, bPass);
      end
      qValidA = 2'b00;
   endtask

   task automatic test_counter();
      srMask = 4'h0;
      pendInc = 1'b1;
      tick(); tick();
      checks++;
      if (aFull !== 1'b0) begin
         errors++; $display("[TB] FAIL cnt_two_full got %b want 0", aFull);
      end
      tick();
      checks++;
      if (aFull !== 1'b1 || bFull !== 1'b1 || aErr !== 1'b0) begin
         errors++; $display("[TB] FAIL cnt_three full %b/%b err %b want 1/1/0", aFull, bFull, aErr);
      end
      tick();
      checks++;
      if (aErr !== 1'b1 || bErr !== 1'b1 || aFull !== 1'b1) begin
         errors++; $display("[TB] FAIL cnt_over err %b/%b full %b want 1/1/1", aErr, bErr, aFull);
      end
      srWe = 1'b1;
      tick();
      checks++;
      if (aFull !== 1'b1) begin
         errors++; $display("[TB] FAIL cnt_incret got full %b want 1", aFull);
      end
      pendInc = 1'b0;
      tick();
      checks++;
      if (aFull !== 1'b0) begin
         errors++; $display("[TB] FAIL cnt_dec got full %b want 0", aFull);
      end
      tick();
      srWe = 1'b0; qCondA = {4'h0, 4'h0};
      #1;
      checks++;
      if (bReady !== 1'b0 || aReady !== 2'b00) begin
         errors++; $display("[TB] FAIL cnt_one got ready %b/%b want 0/00", bReady, aReady);
      end
      srWe = 1'b1;
      tick();
      srIn = 4'b1010; srMask = 4'hF;
      tick();
      srWe = 1'b0;
      checks++;
      if (aStatus !== 4'b1010 || bReady !== 1'b1 || aFull !== 1'b0) begin
         errors++; $display("[TB] FAIL cnt_msr status %b ready %b full %b want 1010/1/0", aStatus, bReady, aFull);
      end
   endtask

   task automatic test_stats();
      statClr = 1'b1;
      tick();
      statClr = 1'b0;
      qCondA = {4'hE, 4'hE}; qValidA = 2'b11;
      tick();
      checks++;
      if (aPassCnt !== 2'd2 || bPassCnt !== 16'd1) begin
         errors++; $display("[TB] FAIL stat_one got %0d/%0d want 2/1", aPassCnt, bPassCnt);
      end
      tick();
      tick();
      checks++;
      if (aPassCnt !== 2'd3 || bPassCnt !== 16'd3) begin
         errors++; $display("[TB] FAIL stat_sat got %0d/%0d want 3/3", aPassCnt, bPassCnt);
      end
      qCondA = {4'hF, 4'hF};
      tick();
      checks++;
      if (aFailCnt !== 2'd2 || bPassCnt !== 16'd4 || bFailCnt !== 16'd0) begin
         errors++; $display("[TB] FAIL stat_nv aFail %0d bPass %0d bFail %0d want 2/4/0", aFailCnt, bPassCnt, bFailCnt);
      end
      statClr = 1'b1; qCondA = {4'hE, 4'hE};
      tick();
      statClr = 1'b0; qValidA = 2'b00;
      checks++;
      if (aPassCnt !== 2'd0 || aFailCnt !== 2'd0 || bPassCnt !== 16'd0) begin
         errors++; $display("[TB] FAIL stat_clr got %0d %0d %0d want 0", aPassCnt, aFailCnt, bPassCnt);
      end
      checks++;
      if (aErr !== 1'b1) begin
         errors++; $display("[TB] FAIL err_sticky got %b want 1", aErr);
      end
   endtask

   task automatic test_back_to_back();
      pendInc = 1'b1;
      tick();
      pendInc = 1'b0;
      qCondA = {4'hE, 4'h0};
      #1;
      checks++;
      if (aReady !== 2'b10) begin
         errors++; $display("[TB] FAIL rst_prestall got %b want 10", aReady);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (aReady !== 2'b11 || bReady !== 1'b1 || aErr !== 1'b0 || aStatus !== 4'h0) begin
         errors++; $display("[TB] FAIL rst_async ready %b/%b err %b status %b", aReady, bReady, aErr, aStatus);
      end
      #2;
      rst = 1'b1;
      tick();
      checks++;
      if (aReady !== 2'b11 || aFull !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_after ready %b full %b want 11/0", aReady, aFull);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_mask();
      test_hazard();
      test_counter();
      test_stats();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
